m_ram_ctrl: RTL and testbench
=============================

// Module: m_ram_ctrl
// PURPOSE
//  Sits upstream of the 16x4 RAM and feeds it. Turns debounced push-switch levels into
//  RAM bus cycles: address select (next/prev), and a write of the 4-bit data switches.
//  Generates a clean we pulse with adr/wdata stable before, during and after the rising
//  edge of we. Registers rdata for the 7-segment decoder downstream.
// PARAMETERS
//  ADR_W        4  address width; address range 0..2**ADR_W-1
//  DAT_W        4  data width
//  SETUP_CYC    1  clk cycles with adr/wdata valid and we=0 before we rises (>=1)
//  WE_CYC       2  clk cycles we is held high (>=1)
// PORTS
//  clk        in   1      system clock
//  rst        in   1      synchronous reset, active-high
//  sw_write   in   1      debounced level, rising edge = write request
//  sw_next    in   1      debounced level, rising edge = address +1
//  sw_prev    in   1      debounced level, rising edge = address -1
//  data_sw    in   DAT_W  data to write, sampled at write acceptance
//  rdata      in   DAT_W  RAM read data (combinational from adr)
//  adr        out  ADR_W  RAM address
//  wdata      out  DAT_W  RAM write data
//  we         out  1      RAM write strobe; RAM writes on its rising edge
//  disp_data  out  DAT_W  registered rdata, to 7-segment decoder
//  busy       out  1      high while a write sequence is in progress
// BEHAVIOUR
//  - Reset (sync, rst=1 at clk edge): adr=0, wdata=0, we=0, busy=0, disp_data=0,
//    state=IDLE, all sync/edge regs=0. Reset mid-sequence aborts it; we=0 on next edge.
//  - sw_* each pass a 2-flop synchronizer, then rising-edge detect -> 1-clk pulse.
//    Input rise to registered action: 3 clk. A held-high switch yields one pulse only.
//  - FSM states: IDLE, SETUP, STROBE, HOLD. busy = (state != IDLE).
//    IDLE  : write pulse -> wdata<=data_sw, go SETUP (SETUP_CYC cycles).
//            else next pulse only -> adr<=adr+1; prev pulse only -> adr<=adr-1;
//            next and prev in same cycle -> adr unchanged.
//    SETUP : we=0; after SETUP_CYC cycles -> STROBE.
//    STROBE: we=1 for exactly WE_CYC cycles -> HOLD.
//    HOLD  : we=0 for 1 cycle, adr/wdata held -> IDLE.
//  - we is a direct register output (glitch-free); high only in STROBE.
//  - adr and wdata are constant from entry to SETUP through end of HOLD.
//  - Write pulse and next/prev pulse in same IDLE cycle: write wins, nav dropped.
//  - Any switch pulse while busy=1 is dropped, not queued.
//  - Address arithmetic modulo 2**ADR_W: 15+1 -> 0, 0-1 -> 15 (ADR_W=4).
//  - disp_data <= rdata every clk (1-clk latency), including during write sequence.
// CONFIGURATION
//  AUTO_INC_EN defined  : on HOLD->IDLE, adr <= adr+1 (mod 2**ADR_W), for sequential
//                         fill; nav pulses behave as above.
//  AUTO_INC_EN undefined: adr unchanged after a write; only next/prev move it.
// TESTING
//  1 rst=1 two clk, all inputs toggling -> adr=0, we=0, busy=0, disp_data=0.
//  2 next x3 (adr=3), data_sw=4'hA, sw_write rise -> we high exactly 2 clk after 1 SETUP
//    clk, adr=3/wdata=A stable SETUP..HOLD, busy 4 clk; then disp_data=4'hA.
//  3 adr=15, next pulse -> adr=0; prev pulse -> adr=15.
//  4 sw_next and sw_prev rise same clk -> adr unchanged; sw_write+sw_next same clk ->
//    write to current adr, adr not incremented (without AUTO_INC_EN).
//  5 sw_next/sw_write rise while busy=1 -> ignored; exactly one we pulse, adr unchanged.
//  6 AUTO_INC_EN: write 1,2,3 from adr=0 -> RAM[0..2]=1,2,3, adr=3; rst during STROBE
//    -> we=0 next clk, adr=0.

Source files
------------

// File: rtl/m_ram_ctrl.sv
// m_ram_ctrl: turns debounced push-switch levels into clean RAM bus cycles and registers read data.
// Optional macro AUTO_INC_EN: advance the address by one after every completed write.
module m_ram_ctrl #(
  parameter int ADR_W     = 4,
  parameter int DAT_W     = 4,
  parameter int SETUP_CYC = 1,
  parameter int WE_CYC    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sw_write,
  input  logic             sw_next,
  input  logic             sw_prev,
  input  logic [DAT_W-1:0] data_sw,
  input  logic [DAT_W-1:0] rdata,
  output logic [ADR_W-1:0] adr,
  output logic [DAT_W-1:0] wdata,
  output logic             we,
  output logic [DAT_W-1:0] disp_data,
  output logic             busy
);

  localparam int CNT_MAX = (SETUP_CYC > WE_CYC) ? SETUP_CYC : WE_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ADR_W-1:0]   adr_r;
  logic [DAT_W-1:0]   wdata_r;
  logic               we_r;
  logic               busy_r;
  logic [DAT_W-1:0]   disp_r;

  // Bit order in the switch vectors: {write, next, prev}
  logic [2:0]         sync1_r;
  logic [2:0]         sync2_r;
  logic [2:0]         edge_r;
  logic [2:0]         pulse_s;
  logic               wr_pulse_s;
  logic               nx_pulse_s;
  logic               pv_pulse_s;

  assign pulse_s    = sync2_r & ~edge_r;
  assign wr_pulse_s = pulse_s[2];
  assign nx_pulse_s = pulse_s[1];
  assign pv_pulse_s = pulse_s[0];

  // Two-flop synchronizer plus edge history for the three switches
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
      edge_r  <= 3'b000;
    end else begin
      sync1_r <= {sw_write, sw_next, sw_prev};
      sync2_r <= sync1_r;
      edge_r  <= sync2_r;
    end
  end

  // Write-sequence FSM; adr/wdata frozen from SETUP entry until HOLD exit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      adr_r   <= {ADR_W{1'b0}};
      wdata_r <= {DAT_W{1'b0}};
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_r <= {CNT_W{1'b0}};
          we_r  <= 1'b0;
          if (wr_pulse_s) begin
            wdata_r <= data_sw;
            busy_r  <= 1'b1;
            state_r <= SETUP;
          end else if (nx_pulse_s && !pv_pulse_s) begin
            adr_r <= adr_r + ADR_W'(1);
          end else if (pv_pulse_s && !nx_pulse_s) begin
            adr_r <= adr_r - ADR_W'(1);
          end else begin
            adr_r <= adr_r;
          end
        end
        SETUP: begin
          if (cnt_r == CNT_W'(SETUP_CYC - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b1;
            state_r <= STROBE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STROBE: begin
          if (cnt_r == CNT_W'(WE_CYC - 1)) begin
            cnt_r   <= {CNT_W{1'b0}};
            we_r    <= 1'b0;
            state_r <= HOLD;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        HOLD: begin
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
`ifdef AUTO_INC_EN
          adr_r   <= adr_r + ADR_W'(1);
`else
          adr_r   <= adr_r;
`endif
        end
        default: begin
          we_r    <= 1'b0;
          busy_r  <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Display register follows RAM read data with one cycle of latency
  always_ff @(posedge clk) begin
    if (rst) begin
      disp_r <= {DAT_W{1'b0}};
    end else begin
      disp_r <= rdata;
    end
  end

  assign adr       = adr_r;
  assign wdata     = wdata_r;
  assign we        = we_r;
  assign busy      = busy_r;
  assign disp_data = disp_r;

endmodule

// File: tb/tb_m_ram_ctrl.sv
// tb_m_ram_ctrl: randomized switch stimulus, reference model of address/RAM contents,
// and a monitor that scores every we pulse against a queue of expected writes.
module tb_m_ram_ctrl;

  localparam int SETUP_CYC = 1;
  localparam int WE_CYC    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sw_write = 1'b0;
  logic       sw_next = 1'b0;
  logic       sw_prev = 1'b0;
  logic [3:0] data_sw = 4'h0;
  logic [3:0] rdata;
  logic [3:0] adr;
  logic [3:0] wdata;
  logic       we;
  logic [3:0] disp_data;
  logic       busy;

  logic [3:0] ram [16];
  logic [3:0] exp_mem [16];
  logic [3:0] exp_adr = 4'h0;
  logic [7:0] wr_q [$];

  int total = 0;
  int bad   = 0;

  m_ram_ctrl #(.ADR_W(4), .DAT_W(4), .SETUP_CYC(SETUP_CYC), .WE_CYC(WE_CYC)) dut (
    .clk(clk), .rst(rst), .sw_write(sw_write), .sw_next(sw_next), .sw_prev(sw_prev),
    .data_sw(data_sw), .rdata(rdata), .adr(adr), .wdata(wdata), .we(we),
    .disp_data(disp_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read, write on rising edge of we
  assign rdata = ram[adr];
  initial begin
    for (int i = 0; i < 16; i++) begin
      ram[i] = 4'h0;
      exp_mem[i] = 4'h0;
    end
    forever begin
      @(posedge we);
      ram[adr] = wdata;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: score each we pulse, its width, busy length and bus stability
  initial begin : monitor
    int we_cnt = 0;
    int busy_cnt = 0;
    bit prev_we = 1'b0;
    bit prev_busy = 1'b0;
    bit stable = 1'b1;
    logic [3:0] cap_adr = 4'h0;
    logic [3:0] cap_wd = 4'h0;
    logic [7:0] ent;
    forever begin
      @(negedge clk);
      if (rst) begin
        we_cnt = 0; busy_cnt = 0; prev_we = 1'b0; prev_busy = 1'b0; stable = 1'b1;
      end else begin
        if (busy) begin
          if (!prev_busy) begin
            cap_adr = adr; cap_wd = wdata; stable = 1'b1;
          end
          busy_cnt++;
          if (adr !== cap_adr || wdata !== cap_wd) stable = 1'b0;
        end else if (prev_busy) begin
          chk("busy_len", busy_cnt, SETUP_CYC + WE_CYC + 1);
          chk("bus_stable", int'(stable), 1);
          busy_cnt = 0;
        end
        if (we && !prev_we) begin
          chk("we_after_setup", busy_cnt, SETUP_CYC + 1);
          if (wr_q.size() == 0) begin
            chk("unexpected_we", 1, 0);
          end else begin
            ent = wr_q.pop_front();
            chk("we_adr", int'(adr), int'(ent[7:4]));
            chk("we_wdata", int'(wdata), int'(ent[3:0]));
          end
        end
        if (we) begin
          we_cnt++;
        end else if (prev_we) begin
          chk("we_width", we_cnt, WE_CYC);
          we_cnt = 0;
        end
        prev_we = we;
        prev_busy = busy;
      end
    end
  end

  // Issue one switch event; model updates the expected address and memory
  task automatic do_op(input bit w, input bit n, input bit p, input logic [3:0] d, input int hold);
    @(negedge clk);
    sw_write = w; sw_next = n; sw_prev = p; data_sw = d;
    if (w) begin
      wr_q.push_back({exp_adr, d});
      exp_mem[exp_adr] = d;
`ifdef AUTO_INC_EN
      exp_adr = exp_adr + 4'd1;
`endif
    end else if (n && !p) begin
      exp_adr = exp_adr + 4'd1;
    end else if (p && !n) begin
      exp_adr = exp_adr - 4'd1;
    end
    repeat (hold) @(negedge clk);
    sw_write = 1'b0; sw_next = 1'b0; sw_prev = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_adr"}, int'(adr), int'(exp_adr));
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_disp"}, int'(disp_data), int'(exp_mem[exp_adr]));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    bit found;
    logic [3:0] d;
    // Reset with all inputs toggling
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      sw_write = 1'($urandom); sw_next = 1'($urandom); sw_prev = 1'($urandom);
      data_sw = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    chk("rst_adr", int'(adr), 0);
    chk("rst_we", int'(we), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_disp", int'(disp_data), 0);
    sw_write = 1'b0; sw_next = 1'b0; sw_prev = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("post_rst_adr", int'(adr), 0);

    // next x3, then write A at address 3
    repeat (3) do_op(1'b0, 1'b1, 1'b0, 4'h0, 4);
    chk("next3_adr", int'(adr), 3);
    do_op(1'b1, 1'b0, 1'b0, 4'hA, 4);
    chk_state("wrA");
    chk("wrA_disp_lit", int'(disp_data), 10);

    // Wrap-around in both directions
    while (exp_adr != 4'hF) do_op(1'b0, 1'b1, 1'b0, 4'h0, 1);
    do_op(1'b0, 1'b1, 1'b0, 4'h0, 2);
    chk("wrap_up", int'(adr), 0);
    do_op(1'b0, 1'b0, 1'b1, 4'h0, 2);
    chk("wrap_down", int'(adr), 15);

    // Simultaneous next+prev, and write+next
    do_op(1'b0, 1'b1, 1'b1, 4'h0, 3);
    chk_state("np_same");
    do_op(1'b1, 1'b1, 1'b0, 4'h5, 3);
    chk_state("wn_same");

    // Randomized mix of operations
    for (int k = 0; k < 30; k++) begin
      int op;
      int hold;
      op = $urandom_range(0, 4);
      hold = $urandom_range(1, 6);
      d = 4'($urandom_range(0, 15));
      case (op)
        0: do_op(1'b0, 1'b1, 1'b0, d, hold);
        1: do_op(1'b0, 1'b0, 1'b1, d, hold);
        2: do_op(1'b0, 1'b1, 1'b1, d, hold);
        3: do_op(1'b1, 1'b0, 1'b0, d, hold);
        default: do_op(1'b1, 1'b1, 1'b0, d, hold);
      endcase
      chk_state("rand");
    end

    // Switch activity while busy is dropped
    d = 4'($urandom_range(0, 15));
    @(negedge clk);
    sw_write = 1'b1; data_sw = d;
    wr_q.push_back({exp_adr, d});
    exp_mem[exp_adr] = d;
`ifdef AUTO_INC_EN
    exp_adr = exp_adr + 4'd1;
`endif
    @(negedge clk);
    sw_write = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (busy) found = 1'b1;
    end
    chk("busy_seen", int'(found), 1);
    sw_next = 1'b1; sw_write = 1'b1; data_sw = ~d;
    repeat (4) @(negedge clk);
    sw_next = 1'b0; sw_write = 1'b0;
    repeat (8) @(negedge clk);
    chk_state("busy_drop");

    // Reset while we is high aborts the sequence
    d = 4'($urandom_range(0, 15));
    @(negedge clk);
    sw_write = 1'b1; data_sw = d;
    wr_q.push_back({exp_adr, d});
    exp_mem[exp_adr] = d;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (we) found = 1'b1;
    end
    chk("we_seen", int'(found), 1);
    rst = 1'b1; sw_write = 1'b0;
    @(negedge clk);
    chk("abort_we", int'(we), 0);
    chk("abort_adr", int'(adr), 0);
    chk("abort_busy", int'(busy), 0);
    rst = 1'b0;
    exp_adr = 4'h0;
    repeat (4) @(negedge clk);
    chk_state("after_abort");
    chk("queue_empty", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
